// File: rtl/multicycle_control_fsm_if.sv
// Control and handshake bundle between the multi-cycle sequencer and the 8-bit RISC datapath.
interface multicycle_control_fsm_if #(
  parameter int COUNT_W = 16
);
  logic               start;
  logic               step;
  logic [3:0]         opcode;
  logic               mem_ready;
  logic               ir_write;
  logic               pc_write;
  logic               jump;
  logic               beq;
  logic               bne;
  logic               mem_read;
  logic               mem_write;
  logic               alu_src;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic [1:0]         alu_op;
  logic               halted;
  logic               fault;
  logic               illegal;
  logic [COUNT_W-1:0] retired;

  modport master (
    input  start, step, opcode, mem_ready,
    output ir_write, pc_write, jump, beq, bne, mem_read, mem_write, alu_src,
           reg_dst, mem_to_reg, reg_write, alu_op, halted, fault, illegal, retired
  );

  modport slave (
    output start, step, opcode, mem_ready,
    input  ir_write, pc_write, jump, beq, bne, mem_read, mem_write, alu_src,
           reg_dst, mem_to_reg, reg_write, alu_op, halted, fault, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) for the 8-bit RISC datapath.
// Optional single-step mode: define STEP_EN to add a PAUSE state released by a rising edge of step.
module multicycle_control_fsm #(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
`ifdef STEP_EN
    , S_PAUSE = 3'd7
`endif
  } state_t;

  typedef enum logic [2:0] {
    C_LD    = 3'd0,
    C_ST    = 3'd1,
    C_RTYPE = 3'd2,
    C_BEQ   = 3'd3,
    C_BNE   = 3'd4,
    C_JMP   = 3'd5,
    C_HLT   = 3'd6,
    C_ILL   = 3'd7
  } cls_t;

  localparam logic [7:0]         WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] RET_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};
`ifdef STEP_EN
  localparam state_t RETIRE_TO = S_PAUSE;
`else
  localparam state_t RETIRE_TO = S_FETCH;
`endif

  function automatic cls_t decode_class(input logic [3:0] op);
    cls_t c;
    case (op)
      4'b0000: c = C_LD;
      4'b0001: c = C_ST;
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000, 4'b1001: c = C_RTYPE;
      4'b1011: c = C_BEQ;
      4'b1100: c = C_BNE;
      4'b1101: c = C_JMP;
      4'b1111: c = C_HLT;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [7:0]         wait_r;
  logic [COUNT_W-1:0] retired_r;
  logic               fault_r;
  cls_t               cls_s;
  logic               level_en_s;
  logic               ir_write_s, pc_write_s, mem_read_s, mem_write_s, reg_write_s;
  logic               illegal_s, retire_s, fault_set_s;
  logic               jump_s, beq_s, bne_s, alu_src_s, reg_dst_s, mem_to_reg_s;
  logic [1:0]         alu_op_s;

  assign cls_s      = decode_class(bus.opcode);
  assign level_en_s = (state_r == S_DECODE) || (state_r == S_EXEC) ||
                      (state_r == S_MEM)    || (state_r == S_WB);

`ifdef STEP_EN
  logic step_prev_r;

  // Previous step level for rising-edge detection in PAUSE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_prev_r <= 1'b0;
    end else begin
      step_prev_r <= bus.step;
    end
  end
`else
  logic unused_step_s;
  assign unused_step_s = bus.step;
`endif

  // Next-state and strobe decode; a retirement is always the cycle carrying pc_write.
  always_comb begin
    state_next_s = state_r;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    fault_set_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_next_s = S_FETCH;
        else           state_next_s = S_IDLE;
      end
      S_FETCH: begin
        ir_write_s   = 1'b1;
        state_next_s = S_DECODE;
      end
      S_DECODE: begin
        case (cls_s)
          C_JMP: begin
            pc_write_s   = 1'b1;
            retire_s     = 1'b1;
            state_next_s = RETIRE_TO;
          end
          C_ILL: begin
            illegal_s    = 1'b1;
            pc_write_s   = 1'b1;
            retire_s     = 1'b1;
            state_next_s = RETIRE_TO;
          end
          C_HLT:   state_next_s = S_HALT;
          default: state_next_s = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_s)
          C_LD, C_ST:   state_next_s = S_MEM;
          C_BEQ, C_BNE: begin
            pc_write_s   = 1'b1;
            retire_s     = 1'b1;
            state_next_s = RETIRE_TO;
          end
          default: state_next_s = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls_s == C_LD) mem_read_s  = 1'b1;
        else               mem_write_s = 1'b1;
        if (bus.mem_ready) begin
          if (cls_s == C_LD) begin
            state_next_s = S_WB;
          end else begin
            pc_write_s   = 1'b1;
            retire_s     = 1'b1;
            state_next_s = RETIRE_TO;
          end
        end else if (wait_r == WAIT_LAST) begin
          fault_set_s  = 1'b1;
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        pc_write_s   = 1'b1;
        retire_s     = 1'b1;
        state_next_s = RETIRE_TO;
      end
      S_HALT: state_next_s = S_HALT;
`ifdef STEP_EN
      S_PAUSE: begin
        if (bus.step && !step_prev_r) state_next_s = S_FETCH;
        else                          state_next_s = S_PAUSE;
      end
`endif
      default: state_next_s = S_IDLE;
    endcase
  end

  // Level controls follow the opcode class only while an instruction is past FETCH.
  always_comb begin
    jump_s       = 1'b0;
    beq_s        = 1'b0;
    bne_s        = 1'b0;
    alu_src_s    = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_op_s     = 2'b00;
    case (level_en_s ? cls_s : C_HLT)
      C_LD: begin
        alu_src_s    = 1'b1;
        mem_to_reg_s = 1'b1;
        alu_op_s     = 2'b10;
      end
      C_ST: begin
        alu_src_s = 1'b1;
        alu_op_s  = 2'b10;
      end
      C_RTYPE: reg_dst_s = 1'b1;
      C_BEQ: begin
        beq_s    = 1'b1;
        alu_op_s = 2'b01;
      end
      C_BNE: begin
        bne_s    = 1'b1;
        alu_op_s = 2'b01;
      end
      C_JMP:   jump_s = 1'b1;
      default: alu_op_s = 2'b00;
    endcase
  end

  // State, MEM wait counter (zero whenever outside MEM), saturating retire count, sticky fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      wait_r    <= 8'd0;
      retired_r <= '0;
      fault_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      wait_r  <= (state_r == S_MEM) ? (wait_r + 8'd1) : 8'd0;
      if (retire_s && (retired_r != '1)) retired_r <= retired_r + RET_ONE;
      if (fault_set_s) fault_r <= 1'b1;
    end
  end

  assign bus.ir_write   = ir_write_s;
  assign bus.pc_write   = pc_write_s;
  assign bus.mem_read   = mem_read_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.illegal    = illegal_s;
  assign bus.jump       = jump_s;
  assign bus.beq        = beq_s;
  assign bus.bne        = bne_s;
  assign bus.alu_src    = alu_src_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.halted     = (state_r == S_HALT);
  assign bus.fault      = fault_r;
  assign bus.retired    = retired_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: a per-instruction-class cycle model predicts every output each cycle.
module tb_multicycle_control_fsm;
  localparam int CW  = 4;
  localparam int TMO = 15;

  localparam int B_IR = 19, B_PC = 18, B_JMP = 17, B_BEQ = 16, B_BNE = 15, B_MR = 14;
  localparam int B_MW = 13, B_ASRC = 12, B_RDST = 11, B_M2R = 10, B_RW = 9, B_AOP = 7;
  localparam int B_HLT = 6, B_FLT = 5, B_ILL = 4;

  localparam int C_LD = 0, C_ST = 1, C_R = 2, C_BEQ = 3, C_BNE = 4, C_JMP = 5, C_HLT = 6, C_ILL = 7;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_fsm_if #(.COUNT_W(CW)) bus ();

  multicycle_control_fsm #(.COUNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] exp_ret;
  bit            exp_fault;
  bit            paused;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400us");
    $fatal(1);
  end

  function automatic logic [19:0] observed();
    return {bus.ir_write, bus.pc_write, bus.jump, bus.beq, bus.bne, bus.mem_read, bus.mem_write,
            bus.alu_src, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_op,
            bus.halted, bus.fault, bus.illegal, bus.retired};
  endfunction

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int classify(input logic [3:0] op);
    if (op == 4'd0) return C_LD;
    if (op == 4'd1) return C_ST;
    if (op >= 4'd2 && op <= 4'd9) return C_R;
    if (op == 4'd11) return C_BEQ;
    if (op == 4'd12) return C_BNE;
    if (op == 4'd13) return C_JMP;
    if (op == 4'd15) return C_HLT;
    return C_ILL;
  endfunction

  function automatic logic [19:0] levels(input int cls);
    logic [19:0] v;
    v = 20'h0;
    case (cls)
      C_LD:  begin v[B_ASRC] = 1'b1; v[B_M2R] = 1'b1; v[B_AOP+1] = 1'b1; end
      C_ST:  begin v[B_ASRC] = 1'b1; v[B_AOP+1] = 1'b1; end
      C_R:   v[B_RDST] = 1'b1;
      C_BEQ: begin v[B_BEQ] = 1'b1; v[B_AOP] = 1'b1; end
      C_BNE: begin v[B_BNE] = 1'b1; v[B_AOP] = 1'b1; end
      C_JMP: v[B_JMP] = 1'b1;
      default: v = 20'h0;
    endcase
    return v;
  endfunction

  function automatic logic [19:0] base();
    return 20'(exp_ret);
  endfunction

  task automatic tick(input string tag, input logic [19:0] exp);
    #1 check_val(tag, observed(), exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_side();
    bus.mem_ready = 1'($urandom);
    bus.start     = 1'($urandom);
`ifndef STEP_EN
    bus.step      = 1'($urandom);
`endif
  endtask

  task automatic retire();
    if (exp_ret != '1) exp_ret = exp_ret + 4'd1;
`ifdef STEP_EN
    paused = 1'b1;
`endif
  endtask

  task automatic run_instr(input logic [3:0] op, input int waits, input bit abort);
    int          cls;
    logic [19:0] lv, e;
    bit          done;
    cls  = classify(op);
    lv   = levels(cls);
    done = 1'b0;
`ifdef STEP_EN
    if (paused) begin
      rand_side(); bus.step = 1'b0; tick("pause_low", base());
      rand_side(); bus.step = 1'b0; tick("pause_hold", base());
      rand_side(); bus.step = 1'b1; tick("pause_edge", base());
      paused = 1'b0;
    end
`endif
    rand_side();
    bus.opcode = 4'($urandom);
    e = base(); e[B_IR] = 1'b1;
    tick("fetch", e);
    bus.opcode = op;
    rand_side();
    e = base() | lv;
    if (cls == C_JMP || cls == C_ILL) e[B_PC] = 1'b1;
    if (cls == C_ILL) e[B_ILL] = 1'b1;
    tick("decode", e);
    if (cls == C_JMP || cls == C_ILL) begin retire(); return; end
    if (cls == C_HLT) return;
    rand_side();
    e = base() | lv;
    if (cls == C_BEQ || cls == C_BNE) e[B_PC] = 1'b1;
    if (abort) begin
      #1 check_val("exec_pre_reset", observed(), e);
      reset = 1'b1;
      #1 check_val("reset_async", observed(), 20'h0);
      @(posedge clk);
      @(negedge clk);
      #1 check_val("reset_next", observed(), 20'h0);
      reset     = 1'b0;
      exp_ret   = '0;
      exp_fault = 1'b0;
      paused    = 1'b0;
      return;
    end
    tick("exec", e);
    if (cls == C_BEQ || cls == C_BNE) begin retire(); return; end
    if (cls == C_LD || cls == C_ST) begin
      for (int k = 0; k < TMO && !done; k++) begin
        bus.start     = 1'($urandom);
        bus.mem_ready = (k == waits);
        e = base() | lv;
        if (cls == C_LD) e[B_MR] = 1'b1;
        else             e[B_MW] = 1'b1;
        if (cls == C_ST && k == waits) e[B_PC] = 1'b1;
        tick("mem", e);
        done = (k == waits);
      end
      if (!done) begin exp_fault = 1'b1; return; end
      if (cls == C_ST) begin retire(); return; end
    end
    rand_side();
    e = base() | lv; e[B_RW] = 1'b1; e[B_PC] = 1'b1;
    tick("wb", e);
    retire();
  endtask

  task automatic halt_cycles(input int n);
    logic [19:0] e;
    for (int i = 0; i < n; i++) begin
      rand_side();
      bus.opcode = 4'($urandom);
      e = base(); e[B_HLT] = 1'b1; e[B_FLT] = exp_fault;
      tick("halt", e);
    end
  endtask

  task automatic idle_then_start(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'b0; bus.mem_ready = 1'($urandom); bus.opcode = 4'($urandom);
      tick("idle", base());
    end
    bus.start = 1'b1;
    tick("idle_start", base());
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.step = 1'b0; bus.opcode = 4'd0; bus.mem_ready = 1'b0;
    exp_ret = '0; exp_fault = 1'b0; paused = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check_val("reset", observed(), 20'h0);
    reset = 1'b0;
    idle_then_start(2);

    for (int i = 0; i < 3; i++) run_instr(4'b0010, 0, 1'b0);
    run_instr(4'b0000, 3, 1'b0);
    run_instr(4'b1011, 0, 1'b0);
    run_instr(4'b1101, 0, 1'b0);
    run_instr(4'b1010, 0, 1'b0);
    for (int i = 0; i < 40; i++) run_instr(4'($urandom_range(14, 0)), int'($urandom_range(4, 0)), 1'b0);

    run_instr(4'b0010, 0, 1'b1);
    idle_then_start(1);
    run_instr(4'b0010, 0, 1'b0);
    run_instr(4'b0001, -1, 1'b0);
    halt_cycles(3);

    reset = 1'b1;
    #1 check_val("reset_from_fault", observed(), 20'h0);
    @(negedge clk);
    reset = 1'b0; exp_ret = '0; exp_fault = 1'b0; paused = 1'b0;
    idle_then_start(1);
    run_instr(4'b1101, 0, 1'b0);
    run_instr(4'b1111, 0, 1'b0);
    halt_cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
